// File: rtl/gesture_seq_power_ctrl.sv
// Gesture and power-key driven power controller: left-then-right powers on,
// right-then-left powers off within a window; power key gives direct on and long-press off.
module gesture_seq_power_ctrl #(
  parameter int unsigned WIN_CYCLES  = 500000000,
  parameter int unsigned LONG_CYCLES = 300000000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_key,
  input  logic             right_key,
  input  logic             power_key,
  output logic             power_state,
  output logic             wait_active,
  output logic [CNT_W-1:0] countdown,
  output logic             on_pulse,
  output logic             off_pulse,
  output logic             timeout_pulse
);

  localparam int unsigned NKEYS = 3;
  localparam int unsigned KL    = 0;
  localparam int unsigned KR    = 1;
  localparam int unsigned KP    = 2;

  typedef enum logic [1:0] {IDLE, WAIT_R, WAIT_L} state_t;

  logic [NKEYS-1:0]                  keys;
  logic [NKEYS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0]            valid_q;
  logic [NKEYS-1:0]                  lvl;
  logic [NKEYS-1:0]                  prev_q;
  logic [NKEYS-1:0]                  armed_q;
  logic [NKEYS-1:0]                  rise;

  state_t           state_q, state_n;
  logic             power_n;
  logic [CNT_W-1:0] cd_n;
  logic [CNT_W-1:0] hold_q, hold_n;
  logic             fired_q, fired_n;
  logic             on_n, off_n, to_n;
  logic             long_fire;
  logic             l_only, r_only, both;

  assign keys = {power_key, right_key, left_key};

  always_comb begin
    for (int k = 0; k < int'(NKEYS); k++) lvl[k] = sync_q[k][SYNC_STAGES-1];
  end

  // A key is armed only after being seen released once the synchronizer holds real data,
  // so a key held across reset cannot produce a press.
  assign rise   = lvl & ~prev_q & armed_q;
  assign both   = rise[KL] & rise[KR];
  assign l_only = rise[KL] & ~rise[KR];
  assign r_only = rise[KR] & ~rise[KL];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      prev_q  <= '0;
      armed_q <= '0;
    end else begin
      for (int k = 0; k < int'(NKEYS); k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], keys[k]};
      end
      valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= lvl;
      armed_q <= armed_q | ({NKEYS{valid_q[SYNC_STAGES-1]}} & ~lvl);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      power_state   <= 1'b0;
      countdown     <= '0;
      hold_q        <= '0;
      fired_q       <= 1'b0;
      on_pulse      <= 1'b0;
      off_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      wait_active   <= 1'b0;
    end else begin
      state_q       <= state_n;
      power_state   <= power_n;
      countdown     <= cd_n;
      hold_q        <= hold_n;
      fired_q       <= fired_n;
      on_pulse      <= on_n;
      off_pulse     <= off_n;
      timeout_pulse <= to_n;
      wait_active   <= (state_n != IDLE);
    end
  end

  // Power-key actions first, then the gesture window FSM.
  always_comb begin
    state_n   = state_q;
    power_n   = power_state;
    cd_n      = countdown;
    hold_n    = '0;
    fired_n   = fired_q & lvl[KP];
    on_n      = 1'b0;
    off_n     = 1'b0;
    to_n      = 1'b0;
    long_fire = 1'b0;

    if (lvl[KP] && power_state && !fired_q) begin
      if (hold_q == CNT_W'(LONG_CYCLES - 1)) long_fire = 1'b1;
      else                                    hold_n    = hold_q + CNT_W'(1);
    end

    if (rise[KP] && !power_state) begin
      power_n = 1'b1;
      on_n    = 1'b1;
      state_n = IDLE;
      cd_n    = '0;
    end else if (long_fire) begin
      power_n = 1'b0;
      off_n   = 1'b1;
      fired_n = 1'b1;
      state_n = IDLE;
      cd_n    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cd_n = '0;
          if (l_only && !power_state) begin
            state_n = WAIT_R;
            cd_n    = CNT_W'(WIN_CYCLES - 1);
          end else if (r_only && power_state) begin
            state_n = WAIT_L;
            cd_n    = CNT_W'(WIN_CYCLES - 1);
          end
        end
        WAIT_R: begin
          if (both) begin
            state_n = IDLE;
            cd_n    = '0;
          end else if (rise[KR] && countdown != '0) begin
            power_n = 1'b1;
            on_n    = 1'b1;
            state_n = IDLE;
            cd_n    = '0;
          end else if (rise[KL]) begin
            cd_n = CNT_W'(WIN_CYCLES - 1);
          end else if (countdown == '0) begin
            to_n    = 1'b1;
            state_n = IDLE;
          end else begin
            cd_n = countdown - CNT_W'(1);
          end
        end
        WAIT_L: begin
          if (both) begin
            state_n = IDLE;
            cd_n    = '0;
          end else if (rise[KL] && countdown != '0) begin
            power_n = 1'b0;
            off_n   = 1'b1;
            state_n = IDLE;
            cd_n    = '0;
          end else if (rise[KR]) begin
            cd_n = CNT_W'(WIN_CYCLES - 1);
          end else if (countdown == '0) begin
            to_n    = 1'b1;
            state_n = IDLE;
          end else begin
            cd_n = countdown - CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cd_n    = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/gesture_seq_power_ctrl.md
GESTURE_SEQ_POWER_CTRL -- requirements
Module: gesture_seq_power_ctrl

Interface
REQ-001 Parameter WIN_CYCLES, default 500000000; gesture window length in clock cycles (5 s at 100 MHz).
REQ-002 Parameter LONG_CYCLES, default 300000000; power-key hold time for forced power-off, in clock cycles.
REQ-003 Parameter CNT_W, default 32; width of the window and hold counters; SHALL hold both WIN_CYCLES and LONG_CYCLES.
REQ-004 Parameter SYNC_STAGES, default 2, minimum 2; synchronizer depth applied to every key input.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 left_key  input  1  asynchronous level, 1 = pressed.
REQ-008 right_key  input  1  asynchronous level, 1 = pressed.
REQ-009 power_key  input  1  asynchronous level, 1 = pressed.
REQ-010 power_state  output  1  1 = powered on.
REQ-011 wait_active  output  1  1 while in WAIT_R or WAIT_L.
REQ-012 countdown  output  CNT_W  remaining window cycles; 0 when IDLE.
REQ-013 on_pulse / off_pulse / timeout_pulse  output  1 each  one-cycle event strobes.

Function
REQ-014 Each key SHALL pass through SYNC_STAGES flops; a press event is a synchronized 0->1 edge, one cycle wide, regardless of hold length.
REQ-015 FSM SHALL have states IDLE, WAIT_R (armed for power-on), WAIT_L (armed for power-off).
REQ-016 IDLE, power_state=0, left edge only -> WAIT_R, countdown loads WIN_CYCLES-1.
REQ-017 IDLE, power_state=1, right edge only -> WAIT_L, countdown loads WIN_CYCLES-1.
REQ-018 In IDLE, simultaneous left and right edges SHALL be ignored; wrong-direction edges for the current power_state SHALL be ignored.
REQ-019 In WAIT states countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-020 WAIT_R with right edge while countdown>0 -> power_state=1 next cycle, on_pulse=1 for one cycle, state IDLE, countdown 0.
REQ-021 WAIT_L with left edge while countdown>0 -> power_state=0 next cycle, off_pulse=1 for one cycle, state IDLE, countdown 0.
REQ-022 Repeated arming-key edge in a WAIT state SHALL reload countdown to WIN_CYCLES-1 (restart window) and stay in the state.
REQ-023 Simultaneous left and right edges in a WAIT state SHALL abort to IDLE with no power change and no pulse.
REQ-024 WAIT state with countdown==0 and no completing edge -> IDLE, timeout_pulse=1 for one cycle, power_state unchanged.
REQ-025 power_key edge while power_state=0 -> power_state=1, on_pulse, state forced IDLE, countdown 0.
REQ-026 power_key held (synchronized level) continuously for LONG_CYCLES cycles while power_state=1 -> power_state=0, off_pulse, state forced IDLE; hold counter SHALL clear on release and SHALL not re-fire until release.
REQ-027 Power-key actions SHALL take priority over any gesture completion or timeout in the same cycle; at most one of on_pulse/off_pulse/timeout_pulse SHALL be high per cycle.
REQ-028 The power_key edge that powers on SHALL NOT count toward the long-press hold; hold counting starts only with power_state=1 at the start of the cycle.
REQ-029 wait_active SHALL equal (state==WAIT_R or state==WAIT_L), registered.

Reset
REQ-030 reset=1 SHALL immediately set state IDLE, power_state 0, countdown 0, all pulses 0, hold counter 0, synchronizer and edge flops 0.
REQ-031 Reset asserted mid-window or mid-hold SHALL abort without any pulse; after release a key already held SHALL produce no edge until released and re-pressed.

Verification (WIN_CYCLES=20, LONG_CYCLES=30, SYNC_STAGES=2)
REQ-032 Off; left press, right press 10 cycles later -> on_pulse once, power_state=1, countdown 0.
REQ-033 Off; left press, no further input -> countdown 19..0, timeout_pulse after 20 window cycles, power_state stays 0.
REQ-034 On; right press, left press at window cycle 15 after a second right press at cycle 10 -> window restarted, off_pulse, power_state=0.
REQ-035 On; power_key held 40 cycles -> off_pulse exactly once, 30 cycles after synchronized assertion; no on_pulse on release.
REQ-036 Off; left and right pressed same cycle -> no state change; then reset pulse during a WAIT_R window -> all outputs 0, no pulse.
